// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, funct3 codes, FSM states and the request-error rule for mem_access_ctrl.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (defined: misaligned accesses trap; undefined: they are aligned down).
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`define LSU_REQ_ERR(we, f3, lo) (mem_access_ctrl_pkg::req_err((we), (f3), (lo)))

package mem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_RMW_WAIT  = 2'd2,
    ST_WRITE     = 2'd3
  } state_t;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // sz is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b01:   return lo[0];
      2'b10:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
`ifdef LSU_MISALIGN_TRAP_EN
    return f3_illegal(we, f3) || misaligned(f3[1:0], lo);
`else
    return f3_illegal(we, f3) || (misaligned(f3[1:0], lo) && 1'b0);
`endif
  endfunction

  // Natural alignment of the byte lane; only matters when misalignment does not trap.
  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bundle of mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [2:0]        req_funct3_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic [DATA_W-1:0] resp_rdata_o;
  logic              resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// mem_lane_align: combinational lane extract/extend for loads and lane merge for SB/SH.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_lane,
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_sdata,
  output logic [DATA_W-1:0] o_ldata,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: 8];
    w_half = i_word[{i_lane[1], 4'b0000} +: 16];

    case (i_funct3)
      F3_B:    o_ldata = {{(DATA_W-8){w_byte[7]}}, w_byte};
      F3_BU:   o_ldata = {{(DATA_W-8){1'b0}}, w_byte};
      F3_H:    o_ldata = {{(DATA_W-16){w_half[15]}}, w_half};
      F3_HU:   o_ldata = {{(DATA_W-16){1'b0}}, w_half};
      default: o_ldata = i_word;
    endcase

    o_merged = i_word;
    case (i_funct3[1:0])
      2'b00:   o_merged[{i_lane, 3'b000} +: 8]      = i_sdata[7:0];
      2'b01:   o_merged[{i_lane[1], 4'b0000} +: 16] = i_sdata[15:0];
      default: o_merged = i_sdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store control ahead of visit_memory: word alignment, SB/SH read-modify-write, load extension.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see package).
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = `ADDR_LEN,
  parameter int DATA_W = `DATA_LEN
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.slave  bus,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_t            r_state;
  logic              r_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_lane;
  logic [DATA_W-1:0] r_sdata;

  logic              w_accept;
  logic              w_err;
  logic [ADDR_W-1:0] w_req_word;
  logic [DATA_W-1:0] w_ldata;
  logic [DATA_W-1:0] w_merged;

  assign w_accept   = bus.req_valid_i & r_ready;
  assign w_err      = `LSU_REQ_ERR(bus.req_we_i, bus.req_funct3_i, bus.req_addr_i[1:0]);
  assign w_req_word = {bus.req_addr_i[ADDR_W-1:2], 2'b00};

  // Read address is live from the request in IDLE so the word arrives during the wait state.
  assign mem_raddr_o = (r_state == ST_IDLE) ? w_req_word : r_addr;

  assign bus.req_ready_o  = r_ready;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_err_o   = r_resp_err;
  assign bus.resp_rdata_o = r_resp_rdata;
  assign mem_wen_o        = r_wen;
  assign mem_waddr_o      = r_waddr;
  assign mem_wdata_o      = r_wdata;

  mem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .i_funct3 (r_f3),
    .i_lane   (r_lane),
    .i_word   (mem_rdata_i),
    .i_sdata  (r_sdata),
    .o_ldata  (w_ldata),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f3    <= bus.req_funct3_i;
      r_addr  <= w_req_word;
      r_lane  <= align_lo(bus.req_funct3_i[1:0], bus.req_addr_i[1:0]);
      r_sdata <= bus.req_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (!bus.req_we_i) begin
              r_state <= ST_LOAD_WAIT;
              r_ready <= 1'b0;
            end else if (bus.req_funct3_i[1:0] == 2'b10) begin
              r_state <= ST_WRITE;
              r_ready <= 1'b0;
              r_wen   <= 1'b1;
              r_waddr <= w_req_word;
              r_wdata <= bus.req_wdata_i;
            end else begin
              r_state <= ST_RMW_WAIT;
              r_ready <= 1'b0;
            end
          end
        end
        ST_LOAD_WAIT: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_ldata;
          r_state      <= ST_IDLE;
          r_ready      <= 1'b1;
        end
        ST_RMW_WAIT: begin
          r_wen   <= 1'b1;
          r_waddr <= r_addr;
          r_wdata <= w_merged;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_wen        <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
          r_state      <= ST_IDLE;
          r_ready      <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-level reference model, directed plan cases and random traffic.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  logic        mem_wen;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_wen_o   (mem_wen),
    .mem_waddr_o (mem_waddr),
    .mem_wdata_o (mem_wdata),
    .mem_raddr_o (mem_raddr),
    .mem_rdata_i (mem_rdata)
  );

  // Environment memory: registered read, write on mem_wen; 256 words aliased by addr[9:2].
  logic [31:0] mem_arr [256];
  always @(posedge clk) begin
    if (mem_wen) mem_arr[mem_waddr[9:2]] <= mem_wdata;
    mem_rdata <= mem_arr[mem_raddr[9:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  resp_t me;
  wr_t   mw;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] last_rdata, last_waddr, last_wdata;
  logic        last_err;

  logic [31:0] model_mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response or a write.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid_o) begin
        last_rdata = bus.resp_rdata_o;
        last_err   = bus.resp_err_o;
        if (rq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          me = rq.pop_front();
          chk("resp_rdata", bus.resp_rdata_o, me.rdata);
          chk("resp_err", {31'd0, bus.resp_err_o}, {31'd0, me.err});
          chk("resp_cycle", cyc, me.cyc);
        end
      end
      if (mem_wen) begin
        last_waddr = mem_waddr;
        last_wdata = mem_wdata;
        if (wq.size() == 0) chk("wen_unexpected", 32'd1, 32'd0);
        else begin
          mw = wq.pop_front();
          chk("wr_addr", mem_waddr, mw.addr);
          chk("wr_data", mem_wdata, mw.data);
          chk("wr_cycle", cyc, mw.cyc);
        end
      end
    end
  end

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] w;
    w = model_mem[a[9:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // Drive one request, wait for acceptance; when track is set, predict its outcome from the ISA rules.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track, output int acc);
    int size;
    bit illegal, mis, err, got;
    logic [31:0] ea, val, word;
    resp_t r;
    wr_t   w;
    size    = 1 << f3[1:0];
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    mis     = (addr % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = illegal || mis;
`else
    err = illegal;
`endif
    ea = addr - (addr % size);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) got = 1;
    end
    if (!got) begin
      chk("ready_timeout", 32'd0, 32'd1);
      bus.req_valid_i = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.req_valid_i = 1'b0;
    if (!track) return;
    if (err) begin
      r = '{32'd0, 1'b1, acc};
      rq.push_back(r);
    end else if (!we) begin
      val = 32'd0;
      for (int i = 0; i < size; i++) val = val | (32'(mbyte(ea + i)) << (8 * i));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
      r = '{val, 1'b0, acc + 1};
      rq.push_back(r);
    end else begin
      word = model_mem[ea[9:2]];
      for (int i = 0; i < size; i++) word[8*((ea + i) % 4) +: 8] = wd[8*i +: 8];
      model_mem[ea[9:2]] = word;
      w = '{{ea[31:2], 2'b00}, word, (size == 4) ? acc : acc + 1};
      wq.push_back(w);
      r = '{32'd0, 1'b0, (size == 4) ? acc + 1 : acc + 2};
      rq.push_back(r);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && wq.size() == 0) done = 1;
    end
    if (!done) begin
      chk("drain_timeout", 32'd0, 32'd1);
      rq.delete();
      wq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
    int acc;
    issue(we, f3, addr, wd, 1, acc);
    drain();
    chk({name, "_rdata"}, last_rdata, exp_rd);
    chk({name, "_err"}, {31'd0, last_err}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2;
    logic [31:0] a;
    rst = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_addr_i   = 32'd0;
    bus.req_wdata_i  = 32'd0;
    last_rdata = '0; last_err = 1'b0; last_waddr = '0; last_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      a = 32'h1357_9BDF ^ (i * 32'h0101_0101) ^ (i << 20);
      mem_arr[i]   <= a;
      model_mem[i]  = a;
    end
    mem_arr[8'h40]   <= 32'h8899_AABB;
    model_mem[8'h40]  = 32'h8899_AABB;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err_o}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata_o, 32'd0);
    chk("rst_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("lw_100",  1'b0, 3'b010, 32'h100, 32'd0, 32'h8899_AABB, 1'b0);
    directed("lb_103",  1'b0, 3'b000, 32'h103, 32'd0, 32'hFFFF_FF88, 1'b0);
    directed("lbu_103", 1'b0, 3'b100, 32'h103, 32'd0, 32'h0000_0088, 1'b0);
    directed("lh_102",  1'b0, 3'b001, 32'h102, 32'd0, 32'hFFFF_8899, 1'b0);
    directed("lhu_100", 1'b0, 3'b101, 32'h100, 32'd0, 32'h0000_AABB, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    directed("lw_102",  1'b0, 3'b010, 32'h102, 32'd0, 32'h0000_0000, 1'b1);
`else
    directed("lw_102",  1'b0, 3'b010, 32'h102, 32'd0, 32'h8899_AABB, 1'b0);
`endif
    directed("illegal_f3", 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 1'b1);

    directed("sb_101", 1'b1, 3'b000, 32'h101, 32'h1234_5677, 32'd0, 1'b0);
    chk("sb_waddr", last_waddr, 32'h100);
    chk("sb_wdata", last_wdata, 32'h8899_77BB);
    directed("lw_after_sb", 1'b0, 3'b010, 32'h100, 32'd0, 32'h8899_77BB, 1'b0);

    issue(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 1, acc1);
    issue(1'b0, 3'b010, 32'h104, 32'd0, 1, acc2);
    chk("b2b_accept_gap", acc2 - acc1, 32'd2);
    drain();
    chk("sw_waddr", last_waddr, 32'h104);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("lw_after_sw", last_rdata, 32'hDEAD_BEEF);

    // Reset while the SB read-modify-write is waiting on read data.
    issue(1'b1, 3'b000, 32'h100, 32'h0000_0055, 0, acc1);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mid_resp", {31'd0, bus.resp_valid_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("rst_mid_mem", mem_arr[8'h40], 32'h8899_77BB);
    @(posedge clk);
    #1;
    directed("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'd0, 32'h8899_77BB, 1'b0);

    directed("sw_top", 1'b1, 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'd0, 1'b0);
    chk("top_waddr", last_waddr, 32'hFFFF_FFFC);
    directed("lh_top", 1'b0, 3'b001, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_CAFE, 1'b0);

    for (int k = 0; k < 200; k++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 9) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else ra = 32'($urandom_range(0, 32'h3FF));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, 1, acc1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store control stage placed directly upstream of the visit_memory stage; it owns that stage's single word-wide port (wen/waddr/wdata/raddr/rdata).
- Accepts one RV32I load or store per handshake.
- Word-aligns the address.
- Performs read-modify-write for SB/SH, since the memory has no byte enables.
- Sign- or zero-extends load data.
- Returns a single registered response to the pipeline.

Parameters:
ADDR_W, 32, address width; equals `ADDR_LEN
DATA_W, 32, data width; equals `DATA_LEN; only 32 supported

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  block can accept; 1 only in IDLE
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  store data, LSB-justified
resp_valid_o  out  1  one-cycle response pulse
resp_rdata_o  out  DATA_W  extended load data; 0 for stores and errors
resp_err_o  out  1  misaligned access or illegal funct3; valid with resp_valid_o
mem_wen_o  out  1  memory write enable, registered
mem_waddr_o  out  ADDR_W  word-aligned write address, registered
mem_wdata_o  out  DATA_W  full write word, registered
mem_raddr_o  out  ADDR_W  word-aligned read address
mem_rdata_i  in  DATA_W  read data, valid one cycle after mem_raddr_o is presented

Behaviour:
- Clock clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_wen_o=0, mem_waddr_o=0, mem_wdata_o=0.
- Accept: req_valid_i & req_ready_o in cycle N.
  - Latch we, funct3, addr, wdata.
  - In IDLE, mem_raddr_o = {req_addr_i[31:2],2'b00} combinationally; otherwise it is driven from the latched address.
- States: IDLE, LOAD_WAIT, RMW_WAIT, WRITE.
- Transitions on accept:
  - Load → LOAD_WAIT.
  - SW → WRITE.
  - SB/SH → RMW_WAIT.
  - Error → stays IDLE.
- LOAD_WAIT (N+1): take byte/half lane by addr[1:0] from mem_rdata_i; sign-extend for LB/LH, zero-extend for LBU/LHU; register into resp_rdata_o; → IDLE. resp_valid_o=1 in N+2.
- RMW_WAIT (N+1): merge req data into mem_rdata_i.
  - SB replaces byte addr[1:0].
  - SH replaces half addr[1].
  - Register merged word into mem_wdata_o and mem_wen_o=1 for N+2; → WRITE.
- SW: mem_wdata_o=wdata and mem_wen_o=1 registered for N+1.
- WRITE: the single mem_wen_o cycle; → IDLE. resp_valid_o=1 next cycle, so SW responds in N+2 and SB/SH in N+3.
- mem_wen_o is high for exactly one cycle per store. mem_waddr_o = {addr[31:2],2'b00}.
- Error (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; funct3 011/110/111, or 100/101 with we=1):
  - No memory write.
  - resp_valid_o=1, resp_err_o=1, resp_rdata_o=0 in N+1.
- resp_valid_o may coincide with a new accept in IDLE; the two are independent.
- Back-to-back: a load following a store to the same word sees the stored data, because the write completes before IDLE re-accepts.
- Address wrap: top address 0xFFFFFFFC handled normally; no increment logic exists.
- Reset mid-operation:
  - All outputs drop to reset values immediately.
  - An in-flight store whose mem_wen_o was not yet asserted is never written.
  - No response is issued for the dropped request.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misalignment handled as the error case above.
- Undefined:
  - Misaligned accesses are not errors.
  - The address low bits are forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access executes normally.
  - Illegal funct3 still reports resp_err_o.

Decomposition:
- Shared defines (alongside `ADDR_LEN/`DATA_LEN): funct3 codes, state encodings, and the error condition as a named macro.
- One natural sub-module: mem_lane_align, purely combinational: lane extract + extend for loads; lane merge for SB/SH.
- FSM and registers stay in mem_access_ctrl.

Test Plan:
- Preload word 0x100=0x8899AABB. LW 0x100 accepted at N → resp_valid at N+2, rdata 0x8899AABB, err 0, mem_wen_o never high.
- Same word:
  - LB 0x103 → 0xFFFFFF88.
  - LBU 0x103 → 0x00000088.
  - LH 0x102 → 0xFFFF8899.
  - LHU 0x100 → 0x0000AABB.
- SB 0x101 wdata 0x12345677 → mem_wen_o at N+2 only, waddr 0x100, wdata 0x889977BB; resp at N+3. A following LW 0x100 returns 0x889977BB.
- SW 0x104 wdata 0xDEADBEEF → mem_wen_o at N+1, waddr 0x104, wdata 0xDEADBEEF; resp at N+2, err 0. Issue a new request in the same cycle as resp_valid and confirm it is accepted.
- LW 0x102:
  - With LSU_MISALIGN_TRAP_EN: resp N+1, err 1, rdata 0, no write.
  - Without: resp N+2 with the word at 0x100, err 0.
- Assert rst during RMW_WAIT of SB 0x100 → mem_wen_o stays 0 and the memory word is unchanged. No resp_valid. After release, req_ready_o=1 and the next LW completes normally.
